neuron_sched: RTL and testbench
===============================

Name: neuron_sched

Overview:
- Round-robin scheduler that shares one two-operand neuron evaluation unit (4-bit x0 / 4-bit x1 packed into 8 bits, 1-bit fire output) among NUM_REQ requesters.
- Accepts one request at a time and issues it to the neuron with a valid/ready handshake.
- Waits for completion with a timeout, then returns the result tagged with the requester id.
- Sits between the per-tile input collectors and the shared neuron core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ), derived, not overridable.
- TIMEOUT, 16, maximum cycles in WAIT before the error path is taken (2..255).
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester request level.
- req_x  in  8*NUM_REQ  packed operands; slice i = {x1[3:0], x0[3:0]} of requester i.
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle.
- nrn_valid  out  1  operand valid to the neuron.
- nrn_x  out  8  operand to the neuron.
- nrn_ready  in  1  neuron accepts the operand.
- nrn_done  in  1  neuron result strobe.
- nrn_y  in  1  neuron fire bit, qualified by nrn_done.
- rsp_valid  out  1  response valid.
- rsp_id  out  ID_W  requester id of the response.
- rsp_y  out  1  fire result.
- rsp_err  out  1  response produced by timeout.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high whenever the FSM is not in IDLE.
- done_cnt  out  CNT_W  completed responses; wraps.
- err_cnt  out  CNT_W  timed-out responses; saturates at all-ones.

Behaviour:

Reset:
- Synchronous; rst wins over every other event.
- State = IDLE; last_id = NUM_REQ-1, so requester 0 has first priority.
- All outputs 0; done_cnt and err_cnt = 0.
- Reset in any state abandons the transaction; a late nrn_done after reset is ignored.

FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- If req != 0, the winner is the first set bit scanning upward from (last_id+1) mod NUM_REQ, wrapping.
- On the edge: latch cur_id and cur_x = req_x slice, set gnt[cur_id]=1 for exactly one cycle, go to ISSUE.
- If req == 0, stay in IDLE.

ISSUE:
- nrn_valid=1 and nrn_x=cur_x, both registered and stable until accepted.
- When nrn_ready=1: nrn_valid drops next cycle, timer clears to 0, go to WAIT.
- nrn_done in ISSUE is ignored.

WAIT:
- Timer increments each cycle.
- nrn_done=1: rsp_y=nrn_y, rsp_err=0, go to RESP.
- Otherwise, when timer == TIMEOUT-1: rsp_y=0, rsp_err=1, go to RESP.
- nrn_done in the same cycle as expiry: done wins; no error.

RESP:
- rsp_valid=1; rsp_id, rsp_y and rsp_err are held stable until rsp_ready.
- On rsp_ready: rsp_valid drops next cycle, last_id=cur_id, go to IDLE.
- done_cnt increments on every accepted response (wraps).
- err_cnt increments on every accepted response with rsp_err=1 (saturates).

Latency:
- req seen in IDLE at edge N gives gnt/nrn_valid in cycle N+1.
- With nrn_ready=1 immediately, WAIT starts at N+2.
- nrn_done at edge M gives rsp_valid in cycle M+1.
- Back-to-back: the next grant comes no earlier than one IDLE cycle after RESP.

Requester rules:
- Hold req and req_x stable until gnt is seen.
- A requester that keeps req high is re-arbitrated behind the others.
- A req deasserted before grant is simply not served; no error.

Decomposition:
- Package neuron_pkg: FSM state enum, default constants (NUM_REQ, TIMEOUT, CNT_W), and the operand layout constant X0_LSB=0 / X1_LSB=4.
- Sub-module rr_arbiter (req, last_id -> winner id + any): purely combinational priority rotate; instantiated once.

Test Plan:
- Single request: req=0001, req_x[7:0]=8'h11, neuron returns done/y=1 two cycles after ready -> gnt=0001 one cycle; nrn_x=8'h11; rsp_valid with rsp_id=0, rsp_y=1, rsp_err=0; done_cnt=1.
- Simultaneous req=1111 held high, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches the slice issued on nrn_x.
- Timeout: nrn_ready=1 but nrn_done never asserted -> rsp_valid exactly TIMEOUT cycles after WAIT entry, rsp_err=1, rsp_y=0, err_cnt=1.
- Done coincident with expiry: nrn_done=1, nrn_y=1 in the final WAIT cycle -> rsp_err=0, rsp_y=1, err_cnt unchanged.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_id and rsp_y stable, no new gnt, busy=1; the cycle after rsp_ready=1 gives busy=0.
- Reset mid-WAIT, then nrn_done pulse -> all outputs 0, state IDLE, no response produced, counters 0; next req=0100 is granted to id 2.

Source files
------------

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_pkg
// Description : Shared types and constants for the neuron scheduler.
//               FSM state encoding, default sizing constants, and the
//               operand field layout inside the packed 8-bit operand.
// Revision    : 1.0  initial release
// ============================================================================
package neuron_pkg;

    // Default sizing of the scheduler
    localparam int c_num_req = 4;   // requesters sharing the neuron
    localparam int c_timeout = 16;  // WAIT cycles before the error path
    localparam int c_cnt_w   = 8;   // statistics counter width

    // Packed operand layout: {x1[3:0], x0[3:0]}
    localparam int c_x_w     = 8;
    localparam int c_x0_lsb  = 0;
    localparam int c_x1_lsb  = 4;

    // Timeout counter width; TIMEOUT is at most 255
    localparam int c_tmr_w   = 8;

    // Scheduler FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_issue = 2'd1;
    localparam state_t c_st_wait  = 2'd2;
    localparam state_t c_st_resp  = 2'd3;

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/neuron_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin priority rotate. The search starts
//               one position above the last served requester and wraps, so
//               the most recently served requester has the lowest priority.
// Ports       : i_req     - request vector
//               i_last_id - id of the last served requester
//               o_winner  - id of the selected requester (0 when none)
//               o_any     - at least one request is pending
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_id,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any
);

    // Walk from the farthest offset to the nearest one so that the nearest
    // set bit (highest priority) is the final assignment.
    always_comb begin : p_rotate
        int w_idx;
        w_idx    = 0;
        o_winner = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_idx = (int'(i_last_id) + off) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_winner = ID_W'(w_idx);
            end
        end
    end

    assign o_any = |i_req;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/neuron_sched.sv
`default_nettype none
// ============================================================================
// Module      : neuron_sched
// Description : Round-robin scheduler sharing one two-operand neuron unit
//               among NUM_REQ requesters. One transaction at a time:
//               arbitrate, issue over valid/ready, wait for completion with
//               a timeout, then present a tagged response over valid/ready.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               req, req_x         - per-requester request and packed operand
//               gnt                - one-cycle one-hot grant pulse
//               nrn_valid/x/ready  - operand handshake to the neuron
//               nrn_done, nrn_y    - neuron result strobe and fire bit
//               rsp_valid/id/y/err - response, held until rsp_ready
//               busy               - FSM not in IDLE
//               done_cnt, err_cnt  - accepted responses (wraps) and timed-out
//                                    responses (saturates)
// Revision    : 1.0  initial release
// ============================================================================
module neuron_sched
    import neuron_pkg::*;
#(
    parameter int  NUM_REQ = c_num_req,
    parameter int  TIMEOUT = c_timeout,
    parameter int  CNT_W   = c_cnt_w,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [c_x_w*NUM_REQ-1:0] req_x,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     nrn_valid,
    output logic [c_x_w-1:0]         nrn_x,
    input  logic                     nrn_ready,
    input  logic                     nrn_done,
    input  logic                     nrn_y,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_y,
    output logic                     rsp_err,
    input  logic                     rsp_ready,
    output logic                     busy,
    output logic [CNT_W-1:0]         done_cnt,
    output logic [CNT_W-1:0]         err_cnt
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [ID_W-1:0]      r_last_id;
    logic [ID_W-1:0]      r_cur_id;
    logic [c_x_w-1:0]     r_cur_x;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_nrn_valid;
    logic [c_tmr_w-1:0]   r_timer;
    logic                 r_rsp_valid;
    logic                 r_rsp_y;
    logic                 r_rsp_err;
    logic [CNT_W-1:0]     r_done_cnt;
    logic [CNT_W-1:0]     r_err_cnt;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [ID_W-1:0]      w_win_id;
    logic                 w_any;
    logic [c_x_w-1:0]     w_win_x;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic                 w_expired;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req     (req),
        .i_last_id (r_last_id),
        .o_winner  (w_win_id),
        .o_any     (w_any)
    );

    assign w_win_x      = req_x[int'(w_win_id)*c_x_w +: c_x_w];
    assign w_win_onehot = NUM_REQ'(1) << w_win_id;

    // Last WAIT cycle: the timer counts 0..TIMEOUT-1 while in WAIT.
    assign w_expired    = (r_timer == c_tmr_w'(TIMEOUT - 1));

    // ------------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_last_id   <= ID_W'(NUM_REQ - 1);  // requester 0 served first
            r_cur_id    <= '0;
            r_cur_x     <= '0;
            r_gnt       <= '0;
            r_nrn_valid <= 1'b0;
            r_timer     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_done_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            // Grant is a single-cycle pulse
            r_gnt <= '0;

            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_cur_id    <= w_win_id;
                        r_cur_x     <= w_win_x;
                        r_gnt       <= w_win_onehot;
                        r_nrn_valid <= 1'b1;
                        r_state     <= c_st_issue;
                    end
                end

                c_st_issue: begin
                    // A stray nrn_done here belongs to nothing we issued
                    if (nrn_ready) begin
                        r_nrn_valid <= 1'b0;
                        r_timer     <= '0;
                        r_state     <= c_st_wait;
                    end
                end

                c_st_wait: begin
                    // Completion takes precedence over a coincident expiry
                    if (nrn_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_y     <= nrn_y;
                        r_rsp_err   <= 1'b0;
                        r_state     <= c_st_resp;
                    end else if (w_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_y     <= 1'b0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= c_st_resp;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                c_st_resp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_last_id   <= r_cur_id;
                        r_done_cnt  <= r_done_cnt + 1'b1;
                        if (r_rsp_err && (r_err_cnt != '1)) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_state     <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt       = r_gnt;
    assign nrn_valid = r_nrn_valid;
    assign nrn_x     = r_cur_x;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_cur_id;
    assign rsp_y     = r_rsp_y;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != c_st_idle);
    assign done_cnt  = r_done_cnt;
    assign err_cnt   = r_err_cnt;

endmodule : neuron_sched
`default_nettype wire

// File: tb/tb_neuron_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_sched
// Description : Scoreboard bench for neuron_sched. Stimulus pushes expected
//               grants and responses; a negedge monitor pops and compares.
//               A small neuron stub answers x1 >= x0 after a set latency.
// Revision    : 1.0  initial release
// ============================================================================
module tb_neuron_sched;
    import neuron_pkg::*;

    localparam int c_nr = 4;
    localparam int c_to = 16;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] x;
    } gnt_t;

    typedef struct packed {
        logic [1:0] id;
        logic       y;
        logic       err;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [31:0]  req_x;
    logic [3:0]   gnt;
    logic         nrn_valid;
    logic [7:0]   nrn_x;
    logic         nrn_ready;
    logic         nrn_done;
    logic         nrn_y;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic         rsp_y;
    logic         rsp_err;
    logic         rsp_ready;
    logic         busy;
    logic [7:0]   done_cnt;
    logic [7:0]   err_cnt;

    logic         auto_done = 1'b0;
    logic         auto_y    = 1'b0;
    logic         man_done  = 1'b0;
    logic         man_y     = 1'b0;
    int           done_lat  = 2;   // 0 = neuron never completes

    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    int           gnt_seen = 0;

    gnt_t         exp_gnt[$];
    rsp_t         exp_rsp[$];

    assign nrn_done = auto_done | man_done;
    assign nrn_y    = auto_y | man_y;

    neuron_sched #(
        .NUM_REQ (c_nr),
        .TIMEOUT (c_to),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x     (req_x),
        .gnt       (gnt),
        .nrn_valid (nrn_valid),
        .nrn_x     (nrn_x),
        .nrn_ready (nrn_ready),
        .nrn_done  (nrn_done),
        .nrn_y     (nrn_y),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .done_cnt  (done_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic fire(input logic [7:0] x);
        return x[c_x1_lsb +: 4] >= x[c_x0_lsb +: 4];
    endfunction

    // Neuron stub: handshake seen at a negedge completes at the following
    // posedge (edge H); nrn_done is then sampled at edge H + done_lat.
    initial begin : p_stub
        logic v_y;
        forever begin
            @(negedge clk);
            if (nrn_valid && nrn_ready && done_lat > 0) begin
                v_y = fire(nrn_x);
                @(posedge clk);
                repeat (done_lat - 1) @(posedge clk);
                #1 auto_done = 1'b1; auto_y = v_y;
                @(posedge clk);
                #1 auto_done = 1'b0; auto_y = 1'b0;
            end
        end
    end

    // Monitor: compare every grant and every accepted response
    always @(negedge clk) begin
        if (!rst && gnt != 4'b0) begin
            gnt_seen++;
            if (exp_gnt.size() == 0) begin
                check("gnt_unexpected", {52'b0, gnt, nrn_x}, 64'h0);
            end else begin
                gnt_t e;
                e = exp_gnt.pop_front();
                check("gnt", gnt, e.g);
                check("nrn_x", nrn_x, e.x);
                check("nrn_valid_at_gnt", nrn_valid, 1);
            end
        end
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", {rsp_id, rsp_y, rsp_err}, 0);
            end else begin
                rsp_t r;
                r = exp_rsp.pop_front();
                check("rsp_id", rsp_id, r.id);
                check("rsp_y", rsp_y, r.y);
                check("rsp_err", rsp_err, r.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the edge number at which the operand handshake completes
    task automatic wait_hs(output int h);
        h = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (nrn_valid && nrn_ready) begin
                h = cyc + 1;
                return;
            end
        end
        check("hs_timeout", 0, 1);
    endtask

    // Returns the edge number at which rsp_valid was raised
    task automatic wait_rsp(output int r);
        r = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r = cyc;
                return;
            end
        end
        check("rsp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    initial begin : p_stim
        int h;
        int r;
        int base;
        rst       = 1'b1;
        req       = 4'b0;
        req_x     = 32'b0;
        nrn_ready = 1'b1;
        rsp_ready = 1'b1;

        // Reset state
        tick(); tick(); tick();
        @(negedge clk);
        check("reset_outputs",
              {28'b0, gnt, nrn_valid, nrn_x, rsp_valid, rsp_id, rsp_y, rsp_err,
               busy, done_cnt, err_cnt}, 64'h0);
        tick();
        rst = 1'b0;

        // Single request, done two cycles after ready
        done_lat = 2;
        req = 4'b0001; req_x = 32'h0000_0011;
        exp_gnt.push_back('{4'b0001, 8'h11});
        exp_rsp.push_back('{2'd0, 1'b1, 1'b0});
        wait_hs(h);
        tick();
        req = 4'b0;
        @(negedge clk);
        check("gnt_one_cycle", gnt, 4'b0);
        check("nrn_valid_drop", nrn_valid, 0);
        check("busy_in_wait", busy, 1);
        wait_rsp(r);
        check("done_to_rsp_latency", r - h, 2);
        wait_idle();
        check("done_cnt_single", done_cnt, 1);

        // Round robin from reset with all requesters held high
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        base  = gnt_seen;
        req   = 4'b1111;
        req_x = 32'h5A77_3421;
        exp_gnt.push_back('{4'b0001, 8'h21}); exp_rsp.push_back('{2'd0, 1'b1, 1'b0});
        exp_gnt.push_back('{4'b0010, 8'h34}); exp_rsp.push_back('{2'd1, 1'b0, 1'b0});
        exp_gnt.push_back('{4'b0100, 8'h77}); exp_rsp.push_back('{2'd2, 1'b1, 1'b0});
        exp_gnt.push_back('{4'b1000, 8'h5A}); exp_rsp.push_back('{2'd3, 1'b0, 1'b0});
        exp_gnt.push_back('{4'b0001, 8'h21}); exp_rsp.push_back('{2'd0, 1'b1, 1'b0});
        for (int i = 0; i < 300 && gnt_seen < base + 5; i++) @(negedge clk);
        check("rr_grant_count", gnt_seen - base, 5);
        tick();
        req = 4'b0;
        wait_idle();
        check("done_cnt_rr", done_cnt, 5);

        // Timeout: neuron never completes
        tick();
        done_lat = 0;
        req = 4'b0100; req_x = 32'h0012_0000;
        exp_gnt.push_back('{4'b0100, 8'h12});
        exp_rsp.push_back('{2'd2, 1'b0, 1'b1});
        wait_hs(h);
        tick();
        req = 4'b0;
        wait_rsp(r);
        check("timeout_latency", r - h, c_to);
        wait_idle();
        check("err_cnt_timeout", err_cnt, 1);
        check("done_cnt_timeout", done_cnt, 6);

        // Done coincident with expiry: done wins
        tick();
        done_lat = c_to;
        req = 4'b1000; req_x = 32'h3300_0000;
        exp_gnt.push_back('{4'b1000, 8'h33});
        exp_rsp.push_back('{2'd3, 1'b1, 1'b0});
        wait_hs(h);
        tick();
        req = 4'b0;
        wait_rsp(r);
        check("coincident_latency", r - h, c_to);
        wait_idle();
        check("err_cnt_coincident", err_cnt, 1);

        // Backpressure with a requester still asserting
        tick();
        done_lat  = 2;
        rsp_ready = 1'b0;
        req = 4'b0001; req_x = 32'h0000_0040;
        exp_gnt.push_back('{4'b0001, 8'h40});
        exp_rsp.push_back('{2'd0, 1'b1, 1'b0});
        wait_rsp(r);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {rsp_valid, rsp_id, rsp_y, rsp_err, busy, gnt},
                  {1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0});
            @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        req = 4'b0;
        tick();
        @(negedge clk);
        check("bp_release", {busy, rsp_valid}, 2'b00);
        check("done_cnt_bp", done_cnt, 8);

        // Reset mid-WAIT followed by a late done pulse
        tick();
        done_lat = 0;
        req = 4'b0001; req_x = 32'h0000_0055;
        exp_gnt.push_back('{4'b0001, 8'h55});
        wait_hs(h);
        tick();
        req = 4'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; man_done = 1'b1; man_y = 1'b1;
        tick();
        man_done = 1'b0; man_y = 1'b0;
        @(negedge clk);
        check("post_reset_outputs",
              {28'b0, gnt, nrn_valid, nrn_x, rsp_valid, rsp_id, rsp_y, rsp_err,
               busy, done_cnt, err_cnt}, 64'h0);
        tick(); tick();
        @(negedge clk);
        check("late_done_ignored", {busy, rsp_valid}, 2'b00);

        tick();
        done_lat = 2;
        req = 4'b0100; req_x = 32'h000F_0000;
        exp_gnt.push_back('{4'b0100, 8'h0F});
        exp_rsp.push_back('{2'd2, 1'b0, 1'b0});
        wait_hs(h);
        tick();
        req = 4'b0;
        wait_idle();
        check("done_cnt_after_reset", done_cnt, 1);
        check("err_cnt_after_reset", err_cnt, 0);

        check("gnt_queue_drained", exp_gnt.size(), 0);
        check("rsp_queue_drained", exp_rsp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule : tb_neuron_sched
`default_nettype wire
